// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle MIPS control unit.
//   - opcode / funct encodings understood by the controller
//   - ALUControl codes, ALUSrcB and PCSrc select codes
//   - 4-bit state encoding (FETCH=0, HALT=F)
package mc_pkg;

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (Instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MEMADR = 4'h2,
    S_MEMRD  = 4'h3,
    S_MEMWB  = 4'h4,
    S_MEMWR  = 4'h5,
    S_EXEC   = 4'h6,
    S_ALUWB  = 4'h7,
    S_BEQ    = 4'h8,
    S_BGTZ   = 4'h9,
    S_ADDIEX = 4'hA,
    S_ADDIWB = 4'hB,
    S_JUMP   = 4'hC,
    S_HALT   = 4'hF
  } state_e;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct decoder.
//   Funct_i    - Instr[5:0]
//   alu_ctl_o  - ALUControl for the decoded function (add when illegal)
//   legal_o    - 1 when Funct_i is one of add/sub/and/or/slt
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] Funct_i,
  output logic [2:0] alu_ctl_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    legal_o   = 1'b1;
    case (Funct_i)
      FN_ADD:  alu_ctl_o = ALU_ADD;
      FN_SUB:  alu_ctl_o = ALU_SUB;
      FN_AND:  alu_ctl_o = ALU_AND;
      FN_OR:   alu_ctl_o = ALU_OR;
      FN_SLT:  alu_ctl_o = ALU_SLT;
      default: legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: Moore control FSM for the multicycle MIPS datapath.
// Inputs : clk, rst (async, active high), Op, Funct (from the IR).
// Outputs: datapath mux selects, write enables and ALUControl, all decoded
//          from the registered state; halted and state for debug.
// Unsupported opcodes/functs trap into a sticky HALT left only via rst.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       Branch,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Bgtz,
  output logic       halted,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [2:0] fn_alu;
  logic       fn_legal;

  // Enables before reset gating
  logic regw_d, branch_d, pcw_d, memw_d, irw_d, bgtz_d;

  mc_alu_dec u_alu_dec (
    .Funct_i  (Funct),
    .alu_ctl_o(fn_alu),
    .legal_o  (fn_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = S_HALT;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = fn_legal ? S_EXEC : S_HALT;
          OP_BEQ:       state_d = S_BEQ;
          OP_BGTZ:      state_d = S_BGTZ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_BGTZ:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Moore output decode
  always_comb begin
    regw_d     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUControl = ALU_ADD;
    PCSrc      = PCSRC_ALU;
    branch_d   = 1'b0;
    pcw_d      = 1'b0;
    IorD       = 1'b0;
    memw_d     = 1'b0;
    irw_d      = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    bgtz_d     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_4;
        irw_d   = 1'b1;
        pcw_d   = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_IMMSH;  // branch target into ALUOut
      // ALUOut reloads every cycle, so the address computation is held
      // through the whole memory sequence.
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        IorD     = 1'b1;
        MemtoReg = 1'b1;
        regw_d   = 1'b1;
      end
      S_MEMWR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        IorD    = 1'b1;
        memw_d  = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
      end
      S_ALUWB: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
        RegDst     = 1'b1;
        regw_d     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch_d   = 1'b1;
      end
      S_BGTZ: begin
        ALUSrcA = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
        bgtz_d  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        regw_d  = 1'b1;
      end
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        pcw_d = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  // Architectural writes are killed combinationally the moment rst rises,
  // so an aborted instruction cannot complete a partial write.
  assign RegWrite = regw_d   & ~rst;
  assign Branch   = branch_d & ~rst;
  assign PCWrite  = pcw_d    & ~rst;
  assign MemWrite = memw_d   & ~rst;
  assign IRWrite  = irw_d    & ~rst;
  assign Bgtz     = bgtz_d   & ~rst;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  logic       clk, rst;
  logic [5:0] Op, Funct;
  logic       RegWrite, ALUSrcA, Branch, PCWrite, IorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, Bgtz, halted;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic       branch;
    logic       pcw;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       bgtz;
    logic       halted;
  } ctl_t;

  ctl_t obs;
  assign obs = {RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Branch, PCWrite,
                IorD, MemWrite, IRWrite, RegDst, MemtoReg, Bgtz, halted};

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .Branch(Branch),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .Bgtz(Bgtz), .halted(halted),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (per-instruction cycle schedule) -------
  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;  // slt; only legal functs reach here
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] op);
    case (op)
      6'b100011: return 5;                          // lw
      6'b101011, 6'b000000, 6'b001000: return 4;    // sw, R, addi
      default:   return 3;                          // beq, bgtz, j
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input logic [5:0] op, input logic [5:0] fn,
                                   input int step);
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    if (step == 0) begin c.srcb = 2'b01; c.irw = 1; c.pcw = 1; return c; end
    if (step == 1) begin c.srcb = 2'b11; return c; end
    case (op)
      6'b100011, 6'b101011: begin
        c.srca = 1; c.srcb = 2'b10;
        if (step >= 3) c.iord = 1;
        if (step == 3 && op == 6'b101011) c.memw = 1;
        if (step == 4) begin c.m2r = 1; c.regw = 1; end
      end
      6'b000000: begin
        c.srca = 1; c.alu = ref_alu(fn);
        if (step == 3) begin c.regdst = 1; c.regw = 1; end
      end
      6'b001000: begin
        c.srca = 1; c.srcb = 2'b10;
        if (step == 3) c.regw = 1;
      end
      6'b000100: begin c.srca = 1; c.alu = 3'b110; c.pcsrc = 2'b01; c.branch = 1; end
      6'b000111: begin c.srca = 1; c.pcsrc = 2'b01; c.bgtz = 1; end
      default:   begin c.pcsrc = 2'b10; c.pcw = 1; end  // j
    endcase
    return c;
  endfunction

  function automatic ctl_t halt_ctl();
    ctl_t c;
    c = '0; c.alu = 3'b010; c.halted = 1;
    return c;
  endfunction

  function automatic ctl_t rst_ctl();
    ctl_t c;
    c = '0; c.alu = 3'b010; c.srcb = 2'b01;
    return c;
  endfunction

  function automatic bit is_legal_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000111, 6'b001000, 6'b000010};
  endfunction

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1; Op = 6'b0; Funct = 6'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== rst_ctl()) $display("FAIL reset_outputs got %h want %h", obs, rst_ctl());
    else n_pass++;
    n_checks++;
    if (state !== 4'h0) $display("FAIL reset_state got %h want 0", state);
    else n_pass++;
    rst = 0; #1;
    n_checks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1)
      $display("FAIL release_fetch got irw=%b pcw=%b want 1 1", IRWrite, PCWrite);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b000111, 6'b000010, 6'b001000};
    logic [5:0] fns[7] = '{6'h15, 6'h2a, 6'b100010, 6'h3f, 6'h00, 6'h11, 6'h22};
    ctl_t e;
    for (int i = 0; i < 7; i++) begin
      Op = ops[i]; Funct = fns[i];
      for (int s = 0; s < instr_len(ops[i]); s++) begin
        e = exp_ctl(ops[i], fns[i], s);
        n_checks++;
        if (obs !== e) $display("FAIL dir op=%b step%0d got %h want %h", ops[i], s, obs, e);
        else n_pass++;
        if (s == 0) begin
          n_checks++;
          if (state !== 4'h0) $display("FAIL dir_fetch op=%b state got %h want 0", ops[i], state);
          else n_pass++;
        end
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b000111, 6'b000010, 6'b001000};
    logic [5:0] rfn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] op, fn;
    ctl_t e;
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 6)];
      fn = (op == 6'b000000) ? rfn[$urandom_range(0, 4)] : 6'($urandom);
      Op = op; Funct = fn;
      for (int s = 0; s < instr_len(op); s++) begin
        e = exp_ctl(op, fn, s);
        n_checks++;
        if (obs !== e) $display("FAIL rand op=%b fn=%b step%0d got %h want %h", op, fn, s, obs, e);
        else n_pass++;
        if (s == 0) begin
          n_checks++;
          if (state !== 4'h0) $display("FAIL rand_fetch state got %h want 0", state);
          else n_pass++;
        end
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    Op = 6'b101011; Funct = 6'h00;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_checks++;
    if (MemWrite !== 1'b1) $display("FAIL memwr_before got %b want 1", MemWrite);
    else n_pass++;
    #1 rst = 1; #1;
    n_checks++;
    if (MemWrite !== 1'b0 || state !== 4'h0)
      $display("FAIL memwr_abort got mw=%b state=%h want 0 0", MemWrite, state);
    else n_pass++;
    n_checks++;
    if (obs !== rst_ctl()) $display("FAIL memwr_abort_outputs got %h want %h", obs, rst_ctl());
    else n_pass++;
    @(negedge clk); rst = 0; #1;
    n_checks++;
    if (obs !== exp_ctl(6'b0, 6'b0, 0)) $display("FAIL memwr_release got %h want %h", obs, exp_ctl(6'b0, 6'b0, 0));
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [5:0] op, fn;
    ctl_t e;
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      begin op = 6'b111111; fn = 6'($urandom); end
      else if (k == 1) begin op = 6'b000000; fn = 6'b000111; end
      else begin
        op = 6'($urandom);
        while (is_legal_op(op)) op = 6'($urandom);
        fn = 6'($urandom);
      end
      Op = op; Funct = fn;
      for (int s = 0; s < 2; s++) begin
        e = exp_ctl(op, fn, s);
        n_checks++;
        if (obs !== e) $display("FAIL ill op=%b step%0d got %h want %h", op, s, obs, e);
        else n_pass++;
        @(posedge clk); @(negedge clk);
      end
      for (int c = 0; c < 100; c++) begin
        Op = 6'($urandom); Funct = 6'($urandom);  // HALT ignores the IR
        n_checks++;
        if (obs !== halt_ctl() || state !== 4'hF)
          $display("FAIL halt op=%b cyc%0d got %h st=%h want %h st=f", op, c, obs, state, halt_ctl());
        else n_pass++;
        @(posedge clk); @(negedge clk);
      end
      rst = 1; #1;
      n_checks++;
      if (state !== 4'h0 || halted !== 1'b0)
        $display("FAIL halt_exit got st=%h halted=%b want 0 0", state, halted);
      else n_pass++;
      @(negedge clk); rst = 0; #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_memwr();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
